// File: rtl/dino_mem_pkg.sv
// Shared constants and types for the dino data-memory slice.
// Holds RAM geometry, the read-owner enum and the arbiter wait default.
package dino_mem_pkg;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int WAIT_W   = 4;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    CPU_RD = 2'd1,
    VGA_RD = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating up-counter with synchronous clear, async active-low reset.
// Ports: clk, rst_n, clr, inc -> cnt (stops at MAX, clr has priority).
module arb_wait_counter #(
  parameter int             W   = 4,
  parameter logic [W-1:0]   MAX = 4'd4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU dmem port and the
// read-only VGA display port; CPU first, VGA forced after MAX_WAIT refusals.
module dmem_arbiter #(
  parameter int ADDR_W   = dino_mem_pkg::ADDR_W,
  parameter int DATA_W   = dino_mem_pkg::DATA_W,
  parameter int MAX_WAIT = dino_mem_pkg::MAX_WAIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_q,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut,
  output logic [15:0]       stall_cnt
);

  import dino_mem_pkg::*;

  localparam logic [WAIT_W-1:0] MAXW = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic              gnt_vga;
  logic              gnt_cpu;
  owner_t            own_d;
  owner_t            own_q;
  logic [DATA_W-1:0] cpu_hold;

  // Gating with reset forces every grant off while reset is held.
  assign gnt_vga = reset & vga_req
                 & (~cpu_req | (wait_cnt == MAXW));
  assign gnt_cpu = reset & cpu_req & ~gnt_vga;

  assign vga_gnt    = gnt_vga;
  assign cpu_stall  = gnt_vga & cpu_req;
  assign ram_addr   = gnt_vga ? vga_addr : cpu_addr;
  assign ram_wEn    = gnt_cpu & cpu_wren;
  assign ram_dataIn = cpu_data;

  arb_wait_counter #(
    .W   (WAIT_W),
    .MAX (MAXW)
  ) u_wait (
    .clk   (clock),
    .rst_n (reset),
    .clr   (~vga_req | gnt_vga),
    .inc   (vga_req & ~gnt_vga),
    .cnt   (wait_cnt)
  );

  always_comb begin
    own_d = NONE;
    unique case (1'b1)
      gnt_vga:              own_d = VGA_RD;
      gnt_cpu & ~cpu_wren:  own_d = CPU_RD;
      default:              own_d = NONE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      own_q <= NONE;
    end else begin
      own_q <= own_d;
    end
  end

  // Last CPU read word, so cpu_q stays stable between loads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_hold <= '0;
    end else if (own_q == CPU_RD) begin
      cpu_hold <= ram_dataOut;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (cpu_stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign vga_valid = (own_q == VGA_RD);
  assign vga_q     = vga_valid ? ram_dataOut : '0;
  assign cpu_q     = (own_q == CPU_RD) ? ram_dataOut : cpu_hold;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter with a behavioural
// RAM and reference model; directed phases followed by random traffic.
module tb_dmem_arbiter;

  localparam int MAXW = 4;

  typedef struct {
    logic        vv;
    logic [31:0] cq;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_wren = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [31:0] cpu_data = '0;
  logic [31:0] cpu_q;
  logic        cpu_stall;
  logic        vga_req = 1'b0;
  logic [11:0] vga_addr = '0;
  logic        vga_gnt;
  logic        vga_valid;
  logic [31:0] vga_q;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic [31:0] ram_dataOut;
  logic [15:0] stall_cnt;

  dmem_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_wren    (cpu_wren),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_q       (cpu_q),
    .cpu_stall   (cpu_stall),
    .vga_req     (vga_req),
    .vga_addr    (vga_addr),
    .vga_gnt     (vga_gnt),
    .vga_valid   (vga_valid),
    .vga_q       (vga_q),
    .ram_wEn     (ram_wEn),
    .ram_addr    (ram_addr),
    .ram_dataIn  (ram_dataIn),
    .ram_dataOut (ram_dataOut),
    .stall_cnt   (stall_cnt)
  );

  always #5 clock = ~clock;

  logic [31:0] ram [0:4095];
  always @(posedge clock) begin
    if (ram_wEn) ram[ram_addr] <= ram_dataIn;
    ram_dataOut <= ram[ram_addr];
  end

  int nvec = 0;
  int nerr = 0;
  bit mon_en = 1'b0;

  logic [31:0] refm [0:4095];
  int          mwait;
  logic [31:0] mhold;
  logic [15:0] mstall;
  logic [31:0] vq [$];
  exp_t        cq [$];
  exp_t        me;
  logic [31:0] mv;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (cq.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL cycq: expectation queue empty");
      end else begin
        me = cq.pop_front();
        chk("vga_valid", {31'd0, vga_valid}, {31'd0, me.vv});
        chk("cpu_q", cpu_q, me.cq);
      end
      if (vga_valid) begin
        if (vq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL vq: vga_valid with no read pending");
        end else begin
          mv = vq.pop_front();
          chk("vga_q", vga_q, mv);
        end
      end
    end
  end

  task automatic step(input logic creq, input logic cwr,
                      input logic [11:0] ca, input logic [31:0] cd,
                      input logic vreq, input logic [11:0] va,
                      output logic vg, output logic st);
    logic cg;
    exp_t e;
    @(posedge clock); #1;
    cpu_req = creq; cpu_wren = cwr;
    cpu_addr = ca; cpu_data = cd;
    vga_req = vreq; vga_addr = va;
    #1;
    vg = vreq && (!creq || mwait == MAXW);
    cg = creq && !vg;
    st = vg && creq;
    chk("vga_gnt", {31'd0, vga_gnt}, {31'd0, vg});
    chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, st});
    chk("ram_wEn", {31'd0, ram_wEn}, {31'd0, cg && cwr});
    chk("ram_addr", {20'd0, ram_addr}, {20'd0, vg ? va : ca});
    if (cg && cwr) chk("ram_dataIn", ram_dataIn, cd);
    chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, mstall});
    if (st && mstall != 16'hFFFF) mstall++;
    if (!vreq || vg) mwait = 0;
    else if (mwait < MAXW) mwait++;
    if (vg) vq.push_back(refm[va]);
    if (cg && !cwr) mhold = refm[ca];
    if (cg && cwr) refm[ca] = cd;
    e.vv = vg;
    e.cq = mhold;
    cq.push_back(e);
  endtask

  task automatic do_reset(input bit midread);
    exp_t e;
    mon_en = 1'b0;
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_wren = !midread; cpu_addr = 12'h005;
    vga_req = 1'b1; vga_addr = 12'h007;
    #2 reset = 1'b0;
    #1;
    chk("rst_vga_gnt", {31'd0, vga_gnt}, 32'd0);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_ram_wEn", {31'd0, ram_wEn}, 32'd0);
    chk("rst_vga_valid", {31'd0, vga_valid}, 32'd0);
    chk("rst_cpu_q", cpu_q, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    repeat (2) begin
      @(negedge clock);
      chk("rst_hold_valid", {31'd0, vga_valid}, 32'd0);
      chk("rst_hold_wEn", {31'd0, ram_wEn}, 32'd0);
    end
    vq.delete(); cq.delete();
    mwait = 0; mhold = '0; mstall = '0;
    @(posedge clock); #1;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_wren = 1'b0; vga_req = 1'b0;
    e.vv = 1'b0; e.cq = '0;
    cq.push_back(e);
    #6 mon_en = 1'b1;
  endtask

  initial begin
    logic vg, st, creq, cwr, vreq;
    logic [11:0] ca, va;
    logic [31:0] cd;
    bit pc, pv;
    int vgrants;
    for (int i = 0; i < 4096; i++) refm[i] = '0;
    mwait = 0; mhold = '0; mstall = '0;
    do_reset(1'b0);

    for (int i = 0; i < 32; i++)
      step(1, 1, 12'(i), $urandom, 0, 0, vg, st);

    step(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, vg, st);
    step(1, 0, 12'h010, 0, 0, 0, vg, st);
    step(0, 0, 12'h000, 0, 0, 0, vg, st);
    step(0, 0, 12'h000, 0, 1, 12'h010, vg, st);
    step(0, 0, 12'h000, 0, 0, 0, vg, st);

    vgrants = 0;
    ca = 12'h001;
    for (int i = 0; i < 15; i++) begin
      step(1, 0, ca, 0, 1, 12'(i * 3 % 32), vg, st);
      if (vg) vgrants++;
      if (!st) ca = 12'(($urandom % 32));
    end
    chk("contention_grants", vgrants, 3);
    step(0, 0, 0, 0, 0, 0, vg, st);

    for (int k = 0; k < 6; k++) begin
      if (k < 4) step(1, 0, 12'h001, 0, 1, 12'h002, vg, st);
      else step(1, 1, 12'h003, 32'hA5A55A5A, k < 5, 12'h004, vg, st);
    end
    step(1, 0, 12'h003, 0, 0, 0, vg, st);
    step(0, 0, 0, 0, 0, 0, vg, st);

    for (int k = 0; k < 3; k++) step(1, 0, 12'h006, 0, 1, 12'h008, vg, st);
    step(1, 0, 12'h006, 0, 0, 12'h008, vg, st);
    step(1, 0, 12'h007, 0, 1, 12'h009, vg, st);
    step(0, 0, 0, 0, 0, 0, vg, st);

    step(0, 0, 0, 0, 1, 12'h010, vg, st);
    do_reset(1'b1);

    pc = 0; pv = 0;
    creq = 0; cwr = 0; ca = 0; cd = 0; vreq = 0; va = 0;
    for (int n = 0; n < 600; n++) begin
      if (!pc) begin
        creq = ($urandom % 4) != 0;
        cwr = ($urandom % 3) == 0;
        ca = 12'($urandom % 32);
        cd = $urandom;
      end
      if (!(pv && ($urandom % 8) != 0)) begin
        vreq = $urandom % 2;
        va = 12'($urandom % 32);
      end
      step(creq, cwr, ca, cd, vreq, va, vg, st);
      pc = st;
      pv = vreq && !vg;
    end

    repeat (3) step(0, 0, 0, 0, 0, 0, vg, st);
    @(negedge clock); #1;
    chk("vq_drain", vq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 4096×32 data RAM between the processor's dmem port and a read-only display port used by the VGA renderer to fetch dino, obstacle and score words. The arbiter sits between the processor's dmem signals and the RAM instance. By default the CPU has priority. A starvation counter guarantees the display port a slot within `MAX_WAIT` cycles; the CPU is stalled for that one cycle.

## Interface
Parameters:
- `ADDR_W`, default 12: RAM word-address width.
- `DATA_W`, default 32: RAM data width.
- `MAX_WAIT`, default 4: maximum cycles a pending display request is refused before it is forced through. Legal range 1..15.

Ports:
- `clock` input, 1 bit: single clock. All state changes on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low. Clears all state immediately.
- `cpu_req` input, 1 bit: CPU memory access this cycle (lw or sw).
- `cpu_wren` input, 1 bit: CPU access is a write. Qualified by `cpu_req`.
- `cpu_addr` input, `ADDR_W` bits: CPU word address.
- `cpu_data` input, `DATA_W` bits: CPU write data.
- `cpu_q` output, `DATA_W` bits: CPU read data.
- `cpu_stall` output, 1 bit: the CPU access was refused this cycle and must be held.
- `vga_req` input, 1 bit: display read request.
- `vga_addr` input, `ADDR_W` bits: display word address.
- `vga_gnt` output, 1 bit: display request accepted this cycle.
- `vga_valid` output, 1 bit: `vga_q` is valid this cycle.
- `vga_q` output, `DATA_W` bits: display read data.
- `ram_wEn` output, 1 bit: RAM write enable.
- `ram_addr` output, `ADDR_W` bits: RAM address.
- `ram_dataIn` output, `DATA_W` bits: RAM write data.
- `ram_dataOut` input, `DATA_W` bits: RAM read data. Synchronous RAM, valid the cycle after the address is presented.
- `stall_cnt` output, 16 bits: saturating count of CPU stall cycles, for debug.

## Operation
Per-cycle grant decision (combinational):
- Grant VGA if `vga_req` and either `!cpu_req` or `wait_cnt == MAX_WAIT`.
- Else grant CPU if `cpu_req`.
- Else no grant.

Outputs by grant:
- **VGA grant:** `ram_addr = vga_addr`, `ram_wEn = 0`, `vga_gnt = 1`, `cpu_stall = cpu_req`.
- **CPU grant:** `ram_addr = cpu_addr`, `ram_wEn = cpu_wren`, `ram_dataIn = cpu_data`.
- **No grant:** `ram_addr` holds `cpu_addr`, `ram_wEn = 0`.

The display port can never write.

`wait_cnt` (4 bits):
- Increments when `vga_req` is high and VGA is not granted.
- Clears on a VGA grant or when `vga_req` is low.
- Saturates at `MAX_WAIT`.

Owner pipeline register `own_q` ∈ {NONE, CPU_RD, VGA_RD}:
- Records the owner of the read issued this cycle. A CPU write records NONE.
- `own_q == VGA_RD`: `vga_valid = 1`, `vga_q = ram_dataOut`.
- `own_q == CPU_RD`: `cpu_q = ram_dataOut`, and the value is captured into `cpu_hold`.
- Otherwise `cpu_q = cpu_hold`.

`stall_cnt` increments on every cycle with `cpu_stall` high and saturates at 0xFFFF.

## Timing
- Grant, `cpu_stall` and the RAM-side outputs are combinational from the request inputs and `wait_cnt`.
- Read latency is 1 cycle: `vga_valid` and a fresh `cpu_q` appear the cycle after the grant.
- Writes take effect at the granting edge.
- A display request may be stalled at most `MAX_WAIT` consecutive cycles.
- The CPU is stalled at most 1 cycle per forced display grant. It can be stalled again only after `MAX_WAIT` further refusals.
- Simultaneous `cpu_req` and `vga_req` with `wait_cnt < MAX_WAIT`: CPU wins and `wait_cnt` increments.
- `vga_req` dropped while waiting: `wait_cnt` clears and there is no grant.
- While `reset` is low:
  - `own_q = NONE`, `cpu_hold = 0`, `wait_cnt = 0`, `stall_cnt = 0`.
  - Grants are forced off: `ram_wEn = 0`, `vga_gnt = 0`, `cpu_stall = 0`, `vga_valid = 0`, `cpu_q = 0`.
- Reset asserted with a read in flight: the read is discarded and no `vga_valid` follows.

## Structure
- Shared package `dino_mem_pkg` holds:
  - `ADDR_W` and `DATA_W` constants.
  - The `owner_t` enum (NONE, CPU_RD, VGA_RD).
  - The `MAX_WAIT` default.
- One sub-module, `arb_wait_counter`: saturating counter with clear and increment inputs, reused for `wait_cnt`.
- Everything else stays inline.

## Test plan
- **Reset:** assert `reset` low mid-read → all outputs 0 at once; no `vga_valid` after release.
- **CPU only:** `cpu_req=1`, `cpu_wren=1`, addr 0x010, data 0xDEADBEEF; next cycle read 0x010 → `cpu_q = 0xDEADBEEF` one cycle later; `cpu_stall` never high.
- **VGA only:** `vga_req=1`, addr 0x010 → `vga_gnt` same cycle; `vga_valid=1` with 0xDEADBEEF the next cycle; `ram_wEn=0`.
- **Contention:** hold `cpu_req` and `vga_req` high with `MAX_WAIT=4` → CPU is granted 4 cycles, VGA is granted on cycle 5 with `cpu_stall=1`, pattern repeats; `stall_cnt` increments once per 5 cycles.
- **Write protection under contention:** CPU write stalled on cycle 5 → RAM unchanged that cycle; write lands on cycle 6; `cpu_q` holds the prior read value throughout.
- **Request withdrawn:** `vga_req` dropped at `wait_cnt=3` → counter clears, no grant, no `vga_valid`.
